fc_spi_cmd_decoder: RTL and testbench

FC_SPI_CMD_DECODER -- requirements
Module: fc_spi_cmd_decoder

---
 rtl/fc_spi_pkg.sv | 25 ++
 rtl/fc_spi_cmd_decoder.sv | 186 ++++++++++++++++++
 tb/tb_fc_spi_cmd_decoder.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fc_spi_pkg.sv
// Shared opcodes, idle TX byte, frame sizes and FSM encoding for the FC SPI command decoder.
package fc_spi_pkg;

  localparam logic [7:0] FC_CMD_WRITE = 8'h01;
  localparam logic [7:0] FC_CMD_READ  = 8'h02;
  localparam logic [7:0] FC_TX_IDLE   = 8'h00;

  localparam int unsigned FC_HDR_BYTES      = 3;
  localparam int unsigned FC_WR_FRAME_BYTES = 5;
  localparam int unsigned FC_RD_FRAME_BYTES = 5;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR_HI,
    ST_ADDR_LO,
    ST_DATA_HI,
    ST_DATA_LO,
    ST_RD_REQ,
    ST_RD_CAP,
    ST_RD_TX_LO,
    ST_RD_TX_END,
    ST_DISCARD
  } fc_state_t;

endpackage

// File: rtl/fc_spi_cmd_decoder.sv
// Decodes FC SPI frames (cmd, addr16, data16) into register write/read strobes and returns
// read data on the SPI TX path; counts aborted or invalid frames with a saturating counter.
module fc_spi_cmd_decoder
  import fc_spi_pkg::*;
#(
  parameter logic [7:0] CMD_WRITE_c = FC_CMD_WRITE,
  parameter logic [7:0] CMD_READ_c  = FC_CMD_READ,
  parameter logic [7:0] TX_IDLE_c   = FC_TX_IDLE
) (
  input  logic        clk210_p,
  input  logic        reset_p,
  input  logic [7:0]  spi_rx_byte_p,
  input  logic        spi_rx_valid_p,
  input  logic        spi_cs_active_p,
  output logic [7:0]  spi_tx_byte_p,
  output logic        spi_tx_load_p,
  output logic [15:0] memory_map_spi_wr_addr_p,
  output logic [15:0] memory_map_spi_wr_data_p,
  output logic        memory_map_spi_wr_en_p,
  output logic [15:0] memory_map_spi_rd_addr_p,
  output logic        memory_map_spi_rd_en_p,
  input  logic [15:0] memory_map_spi_rd_data_p,
  output logic [15:0] frame_error_count_p
);

  fc_state_t   r_state;
  fc_state_t   w_next_state;

  logic        r_is_wr;
  logic [7:0]  r_addr_hi;
  logic [7:0]  r_addr_lo;
  logic [7:0]  r_data_hi;
  logic [7:0]  r_rd_lo;
  logic [15:0] r_wr_addr;
  logic [15:0] r_wr_data;
  logic        r_wr_en;
  logic [15:0] r_rd_addr;
  logic [7:0]  r_tx_byte;
  logic        r_tx_load;
  logic [15:0] r_err_cnt;

  logic        w_rx;
  logic        w_err_inc;
  logic        w_wr_commit;
  logic        w_tx_hi;
  logic        w_tx_lo;
  logic        w_tx_end;

  assign w_rx = spi_rx_valid_p & spi_cs_active_p;

  always_ff @(posedge clk210_p) begin
    if (reset_p) r_state <= ST_IDLE;
    else         r_state <= w_next_state;
  end

  // CS loss outranks byte decoding; DISCARD already counted its error on entry.
  always_comb begin
    w_next_state = r_state;
    w_err_inc    = 1'b0;
    w_wr_commit  = 1'b0;
    w_tx_hi      = 1'b0;
    w_tx_lo      = 1'b0;
    w_tx_end     = 1'b0;
    if (!spi_cs_active_p) begin
      if (r_state != ST_IDLE) begin
        w_next_state = ST_IDLE;
        w_err_inc    = (r_state != ST_DISCARD);
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_rx) begin
            if ((spi_rx_byte_p == CMD_WRITE_c) || (spi_rx_byte_p == CMD_READ_c)) begin
              w_next_state = ST_ADDR_HI;
            end else begin
              w_next_state = ST_DISCARD;
              w_err_inc    = 1'b1;
            end
          end
        end
        ST_ADDR_HI: if (w_rx) w_next_state = ST_ADDR_LO;
        ST_ADDR_LO: if (w_rx) w_next_state = r_is_wr ? ST_DATA_HI : ST_RD_REQ;
        ST_DATA_HI: if (w_rx) w_next_state = ST_DATA_LO;
        ST_DATA_LO: begin
          if (w_rx) begin
            w_next_state = ST_IDLE;
            w_wr_commit  = 1'b1;
          end
        end
        ST_RD_REQ: begin
          if (w_rx) begin
            w_next_state = ST_DISCARD;
            w_err_inc    = 1'b1;
          end else begin
            w_next_state = ST_RD_CAP;
          end
        end
        ST_RD_CAP: begin
          if (w_rx) begin
            w_next_state = ST_DISCARD;
            w_err_inc    = 1'b1;
          end else begin
            w_next_state = ST_RD_TX_LO;
            w_tx_hi      = 1'b1;
          end
        end
        ST_RD_TX_LO: begin
          if (w_rx) begin
            w_next_state = ST_RD_TX_END;
            w_tx_lo      = 1'b1;
          end
        end
        ST_RD_TX_END: begin
          if (w_rx) begin
            w_next_state = ST_IDLE;
            w_tx_end     = 1'b1;
          end
        end
        ST_DISCARD: w_next_state = ST_DISCARD;
        default:    w_next_state = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk210_p) begin
    if (reset_p) begin
      r_is_wr   <= 1'b0;
      r_addr_hi <= '0;
      r_addr_lo <= '0;
      r_data_hi <= '0;
      r_rd_lo   <= '0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_wr_en   <= 1'b0;
      r_rd_addr <= '0;
      r_tx_byte <= TX_IDLE_c;
      r_tx_load <= 1'b0;
    end else begin
      r_wr_en   <= w_wr_commit;
      r_tx_load <= w_tx_hi | w_tx_lo | w_tx_end;
      if (w_rx) begin
        case (r_state)
          ST_IDLE:    r_is_wr   <= (spi_rx_byte_p == CMD_WRITE_c);
          ST_ADDR_HI: r_addr_hi <= spi_rx_byte_p;
          ST_ADDR_LO: begin
            r_addr_lo <= spi_rx_byte_p;
            if (!r_is_wr) r_rd_addr <= {r_addr_hi, spi_rx_byte_p};
          end
          ST_DATA_HI: r_data_hi <= spi_rx_byte_p;
          default: ;
        endcase
      end
      // Write outputs only move on commit so they stay stable across the strobe.
      if (w_wr_commit) begin
        r_wr_addr <= {r_addr_hi, r_addr_lo};
        r_wr_data <= {r_data_hi, spi_rx_byte_p};
      end
      if (w_tx_hi) begin
        r_tx_byte <= memory_map_spi_rd_data_p[15:8];
        r_rd_lo   <= memory_map_spi_rd_data_p[7:0];
      end else if (w_tx_lo) begin
        r_tx_byte <= r_rd_lo;
      end else if (w_tx_end) begin
        r_tx_byte <= TX_IDLE_c;
      end
    end
  end

  always_ff @(posedge clk210_p) begin
    if (reset_p) begin
      r_err_cnt <= '0;
    end else if (w_err_inc && (r_err_cnt != '1)) begin
      r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign spi_tx_byte_p            = r_tx_byte;
  assign spi_tx_load_p            = r_tx_load;
  assign memory_map_spi_wr_addr_p = r_wr_addr;
  assign memory_map_spi_wr_data_p = r_wr_data;
  assign memory_map_spi_wr_en_p   = r_wr_en;
  assign memory_map_spi_rd_addr_p = r_rd_addr;
  assign memory_map_spi_rd_en_p   = (r_state == ST_RD_REQ) || (r_state == ST_RD_CAP);
  assign frame_error_count_p      = r_err_cnt;

endmodule

// File: tb/tb_fc_spi_cmd_decoder.sv
// Directed bench for fc_spi_cmd_decoder: write/read frames, bad cmd, CS loss, aborts, reset, saturation.
module tb_fc_spi_cmd_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        cs;
  logic [7:0]  tx_byte;
  logic        tx_load;
  logic [15:0] wr_addr;
  logic [15:0] wr_data;
  logic        wr_en;
  logic [15:0] rd_addr;
  logic        rd_en;
  logic [15:0] rd_data;
  logic [15:0] err_cnt;

  always #5 clk = ~clk;

  fc_spi_cmd_decoder #(
    .CMD_WRITE_c(8'h01),
    .CMD_READ_c (8'h02),
    .TX_IDLE_c  (8'h00)
  ) dut (
    .clk210_p                (clk),
    .reset_p                 (reset),
    .spi_rx_byte_p           (rx_byte),
    .spi_rx_valid_p          (rx_valid),
    .spi_cs_active_p         (cs),
    .spi_tx_byte_p           (tx_byte),
    .spi_tx_load_p           (tx_load),
    .memory_map_spi_wr_addr_p(wr_addr),
    .memory_map_spi_wr_data_p(wr_data),
    .memory_map_spi_wr_en_p  (wr_en),
    .memory_map_spi_rd_addr_p(rd_addr),
    .memory_map_spi_rd_en_p  (rd_en),
    .memory_map_spi_rd_data_p(rd_data),
    .frame_error_count_p     (err_cnt)
  );

  // Register file model: data appears the cycle after rd_en.
  always @(posedge clk) begin
    if (rd_en) rd_data <= (rd_addr == 16'h0052) ? 16'h07D0 : {rd_addr[7:0], ~rd_addr[7:0]};
  end

  int          cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          wr_cnt, rd_cnt, overlap;
  logic [15:0] wr_addr_q[$];
  logic [15:0] wr_data_q[$];
  logic [15:0] last_rd_addr;
  logic [7:0]  tx_q[$];
  int          tx_cyc_q[$];
  int          rx_cyc_q[$];
  int          wr_cyc_q[$];
  int          rd_cyc_q[$];

  always @(negedge clk) begin
    if (!reset) begin
      if (rx_valid && cs) rx_cyc_q.push_back(cyc);
      if (wr_en) begin
        wr_cnt++;
        wr_addr_q.push_back(wr_addr);
        wr_data_q.push_back(wr_data);
        wr_cyc_q.push_back(cyc);
      end
      if (rd_en) begin
        rd_cnt++;
        last_rd_addr = rd_addr;
        rd_cyc_q.push_back(cyc);
      end
      if (tx_load) begin
        tx_q.push_back(tx_byte);
        tx_cyc_q.push_back(cyc);
      end
      if (wr_en && rd_en) overlap++;
    end
  end

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_mon();
    wr_cnt       = 0;
    rd_cnt       = 0;
    last_rd_addr = '0;
    wr_addr_q.delete();
    wr_data_q.delete();
    tx_q.delete();
    tx_cyc_q.delete();
    rx_cyc_q.delete();
    wr_cyc_q.delete();
    rd_cyc_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(posedge clk); #1;
    rx_byte  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    repeat (gap) @(posedge clk);
  endtask

  task automatic send5(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                       input logic [7:0] b3, input logic [7:0] b4);
    send_byte(b0, 6);
    send_byte(b1, 6);
    send_byte(b2, 6);
    send_byte(b3, 6);
    send_byte(b4, 6);
  endtask

  task automatic set_cs(input logic v);
    @(posedge clk); #1;
    cs = v;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    reset    = 1'b1;
    rx_byte  = '0;
    rx_valid = 1'b0;
    cs       = 1'b0;
    overlap  = 0;
    clr_mon();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);

    check_eq("rst_wr_en",   32'(wr_en),   32'h0);
    check_eq("rst_rd_en",   32'(rd_en),   32'h0);
    check_eq("rst_tx_load", 32'(tx_load), 32'h0);
    check_eq("rst_tx_byte", 32'(tx_byte), 32'h00);
    check_eq("rst_wr_addr", 32'(wr_addr), 32'h0);
    check_eq("rst_wr_data", 32'(wr_data), 32'h0);
    check_eq("rst_rd_addr", 32'(rd_addr), 32'h0);
    check_eq("rst_err",     32'(err_cnt), 32'h0);

    // Write frame
    set_cs(1'b1);
    clr_mon();
    send5(8'h01, 8'h00, 8'h53, 8'h00, 8'h01);
    check_eq("wr_count",   32'(wr_cnt), 32'd1);
    check_eq("wr_addr",    32'(wr_addr_q[0]), 32'h0053);
    check_eq("wr_data",    32'(wr_data_q[0]), 32'h0001);
    check_eq("wr_no_rd",   32'(rd_cnt), 32'd0);
    check_eq("wr_latency", 32'(wr_cyc_q[0] - rx_cyc_q[4]), 32'd1);
    check_eq("wr_err",     32'(err_cnt), 32'h0);
    set_cs(1'b0);

    // Read frame
    set_cs(1'b1);
    clr_mon();
    send5(8'h02, 8'h00, 8'h52, 8'hAA, 8'h55);
    check_eq("rd_count",    32'(rd_cnt), 32'd2);
    check_eq("rd_addr",     32'(last_rd_addr), 32'h0052);
    check_eq("rd_en_start", 32'(rd_cyc_q[0] - rx_cyc_q[2]), 32'd1);
    check_eq("rd_en_end",   32'(rd_cyc_q[1] - rx_cyc_q[2]), 32'd2);
    check_eq("rd_tx_n",     32'(tx_q.size()), 32'd3);
    check_eq("rd_tx0",      32'(tx_q[0]), 32'h07);
    check_eq("rd_tx1",      32'(tx_q[1]), 32'hD0);
    check_eq("rd_tx2",      32'(tx_q[2]), 32'h00);
    check_eq("rd_tx0_lat",  32'(tx_cyc_q[0] - rx_cyc_q[2]), 32'd3);
    check_eq("rd_tx1_lat",  32'(tx_cyc_q[1] - rx_cyc_q[3]), 32'd1);
    check_eq("rd_tx2_lat",  32'(tx_cyc_q[2] - rx_cyc_q[4]), 32'd1);
    check_eq("rd_no_wr",    32'(wr_cnt), 32'd0);
    check_eq("rd_err",      32'(err_cnt), 32'h0);
    set_cs(1'b0);

    // Bad cmd; trailing bytes (including a write opcode) must be discarded
    set_cs(1'b1);
    clr_mon();
    send5(8'h7F, 8'h01, 8'h00, 8'h10, 8'h00);
    check_eq("bad_err",   32'(err_cnt), 32'h1);
    check_eq("bad_no_wr", 32'(wr_cnt), 32'd0);
    check_eq("bad_no_rd", 32'(rd_cnt), 32'd0);
    set_cs(1'b0);
    check_eq("bad_cs_err", 32'(err_cnt), 32'h1);
    set_cs(1'b1);
    clr_mon();
    send5(8'h01, 8'h12, 8'h34, 8'hAB, 8'hCD);
    check_eq("post_bad_wr_n",    32'(wr_cnt), 32'd1);
    check_eq("post_bad_wr_addr", 32'(wr_addr_q[0]), 32'h1234);
    check_eq("post_bad_wr_data", 32'(wr_data_q[0]), 32'hABCD);
    set_cs(1'b0);

    // CS dropped after byte3 of a write
    set_cs(1'b1);
    clr_mon();
    send_byte(8'h01, 6);
    send_byte(8'h00, 6);
    send_byte(8'h60, 6);
    send_byte(8'hAA, 6);
    set_cs(1'b0);
    check_eq("csdrop_no_wr", 32'(wr_cnt), 32'd0);
    check_eq("csdrop_err",   32'(err_cnt), 32'h2);
    set_cs(1'b1);
    send5(8'h01, 8'h00, 8'h61, 8'h12, 8'h34);
    check_eq("csdrop_next_n",    32'(wr_cnt), 32'd1);
    check_eq("csdrop_next_addr", 32'(wr_addr_q[0]), 32'h0061);
    check_eq("csdrop_next_data", 32'(wr_data_q[0]), 32'h1234);
    set_cs(1'b0);

    // Two writes within one CS
    set_cs(1'b1);
    clr_mon();
    send5(8'h01, 8'h00, 8'h10, 8'h11, 8'h11);
    send5(8'h01, 8'h00, 8'h20, 8'h22, 8'h22);
    check_eq("b2b_n",     32'(wr_cnt), 32'd2);
    check_eq("b2b_addr0", 32'(wr_addr_q[0]), 32'h0010);
    check_eq("b2b_addr1", 32'(wr_addr_q[1]), 32'h0020);
    check_eq("b2b_data1", 32'(wr_data_q[1]), 32'h2222);
    check_eq("b2b_err",   32'(err_cnt), 32'h2);
    set_cs(1'b0);

    // Bytes while CS is low are ignored
    clr_mon();
    send5(8'h01, 8'h00, 8'h80, 8'h00, 8'h01);
    check_eq("cslow_no_wr", 32'(wr_cnt), 32'd0);
    set_cs(1'b1);
    send5(8'h01, 8'h00, 8'h81, 8'h5A, 8'hA5);
    check_eq("cslow_next_n",    32'(wr_cnt), 32'd1);
    check_eq("cslow_next_addr", 32'(wr_addr_q[0]), 32'h0081);
    check_eq("cslow_err",       32'(err_cnt), 32'h2);
    set_cs(1'b0);

    // Byte arriving during RD_CAP aborts the read
    set_cs(1'b1);
    clr_mon();
    send_byte(8'h02, 6);
    send_byte(8'h00, 6);
    send_byte(8'h52, 0);
    send_byte(8'hEE, 6);
    check_eq("abort_err",   32'(err_cnt), 32'h3);
    check_eq("abort_no_tx", 32'(tx_q.size()), 32'd0);
    check_eq("abort_rd_n",  32'(rd_cnt), 32'd2);
    send_byte(8'h01, 6);
    check_eq("abort_discard", 32'(err_cnt), 32'h3);
    set_cs(1'b0);
    check_eq("abort_cs_err", 32'(err_cnt), 32'h3);

    // Reset mid-frame
    set_cs(1'b1);
    clr_mon();
    send_byte(8'h01, 6);
    send_byte(8'h00, 6);
    send_byte(8'h70, 6);
    send_byte(8'h55, 2);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rstmid_no_wr", 32'(wr_cnt), 32'd0);
    check_eq("rstmid_err",   32'(err_cnt), 32'h0);
    send5(8'h01, 8'h00, 8'h71, 8'h00, 8'h09);
    check_eq("rstmid_next_addr", 32'(wr_addr_q[0]), 32'h0071);
    set_cs(1'b0);

    // Saturation
    @(posedge clk); #1;
    force dut.r_err_cnt = 16'hFFFF;
    @(posedge clk); #1;
    release dut.r_err_cnt;
    @(posedge clk); #1;
    check_eq("sat_preload", 32'(err_cnt), 32'hFFFF);
    set_cs(1'b1);
    send_byte(8'h7F, 6);
    check_eq("sat_hold", 32'(err_cnt), 32'hFFFF);
    set_cs(1'b0);

    check_eq("no_wr_rd_overlap", 32'(overlap), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
